// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one Wishbone-classic master between the instruction-fetch port and
// the LSU data port. One bus cycle is in flight at a time; the winner gets the
// read data together with a one-cycle ack or err pulse.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a bus watchdog that forces
// an error when the slave stays silent for TIMEOUT_CYCLES cycles. Without the
// macro a bus cycle waits indefinitely for wb_ack_i/wb_err_i.
//
// Reset is synchronous and active-low on rst_i.

module mem_bus_arbiter #(
  parameter bit          LSU_PRIO       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction-fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_dat_o,
  output logic        if_ack_o,
  output logic        if_err_o,
  // LSU port
  input  logic        lsu_re_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_dat_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  // Wishbone master
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_IF  = 2'd1,
    ST_BUS_LSU = 2'd2
  } state_t;

  // A watchdog limit of 0 would fire before the slave could ever answer, and
  // the counter is only 16 bits wide.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t state;
  logic   last_grant_lsu;   // 1: the most recent grant went to the LSU
  logic   cyc_q;            // drives both wb_cyc_o and wb_stb_o

  logic   lsu_req;
  logic   if_elig;
  logic   lsu_elig;
  logic   lsu_wins_tie;
  logic   grant_lsu;
  logic   grant_if;
  logic   bus_timeout;
  logic   rsp_done;
  logic   rsp_err;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] timeout_cnt;

  // Watchdog: counts silent bus cycles, held at 0 outside a bus cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      timeout_cnt <= '0;
    end else if (state == ST_IDLE || rsp_done) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

  assign bus_timeout = (timeout_cnt >= TIMEOUT_LIMIT);
`else
  assign bus_timeout = 1'b0;
`endif

  // Arbitration and bus-response decode for the current cycle.
  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    lsu_req      = 1'b0;
    if_elig      = 1'b0;
    lsu_elig     = 1'b0;
    lsu_wins_tie = 1'b0;
    grant_lsu    = 1'b0;
    grant_if     = 1'b0;
    rsp_done     = 1'b0;
    rsp_err      = 1'b0;

    lsu_req  = lsu_re_i | lsu_we_i;
    // A port that is seeing its ack/err this cycle has not yet had a chance
    // to drop its request, so it must not be granted again.
    if_elig  = if_req_i & ~if_ack_o & ~if_err_o;
    lsu_elig = lsu_req & ~lsu_ack_o & ~lsu_err_o;

    lsu_wins_tie = LSU_PRIO ? 1'b1 : ~last_grant_lsu;
    grant_lsu    = lsu_elig & (~if_elig | lsu_wins_tie);
    grant_if     = if_elig & ~grant_lsu;

    // Slave error beats a simultaneous ack; a real ack beats the watchdog.
    rsp_done = wb_ack_i | wb_err_i | bus_timeout;
    rsp_err  = wb_err_i | (~wb_ack_i & bus_timeout);
  end

  // Bus sequencer: grants in IDLE, waits for the slave in BUS_x, and
  // produces the registered bus outputs and per-port response pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state          <= ST_IDLE;
      last_grant_lsu <= 1'b1;
      cyc_q          <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_sel_o       <= 4'h0;
      wb_adr_o       <= 32'h0;
      wb_dat_o       <= 32'h0;
      if_dat_o       <= 32'h0;
      if_ack_o       <= 1'b0;
      if_err_o       <= 1'b0;
      lsu_dat_o      <= 32'h0;
      lsu_ack_o      <= 1'b0;
      lsu_err_o      <= 1'b0;
    end else begin
      // Response pulses and their data last exactly one cycle.
      if_ack_o  <= 1'b0;
      if_err_o  <= 1'b0;
      if_dat_o  <= 32'h0;
      lsu_ack_o <= 1'b0;
      lsu_err_o <= 1'b0;
      lsu_dat_o <= 32'h0;

      unique case (state)
        ST_IDLE: begin
          if (grant_lsu) begin
            state          <= ST_BUS_LSU;
            last_grant_lsu <= 1'b1;
            cyc_q          <= 1'b1;
            wb_we_o        <= lsu_we_i;
            wb_sel_o       <= lsu_sel_i;
            wb_adr_o       <= lsu_addr_i;
            wb_dat_o       <= lsu_dat_i;
          end else if (grant_if) begin
            state          <= ST_BUS_IF;
            last_grant_lsu <= 1'b0;
            cyc_q          <= 1'b1;
            wb_we_o        <= 1'b0;
            wb_sel_o       <= 4'hF;
            wb_adr_o       <= if_addr_i;
            wb_dat_o       <= 32'h0;
          end
        end

        ST_BUS_IF, ST_BUS_LSU: begin
          // Requests are deliberately not looked at here: once issued, the
          // bus cycle always runs to completion.
          if (rsp_done) begin
            state    <= ST_IDLE;
            cyc_q    <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            if (state == ST_BUS_LSU) begin
              if (rsp_err) begin
                lsu_err_o <= 1'b1;
              end else begin
                lsu_ack_o <= 1'b1;
                lsu_dat_o <= wb_we_o ? 32'h0 : wb_dat_i;
              end
            end else begin
              if (rsp_err) begin
                if_err_o <= 1'b1;
              end else begin
                if_ack_o <= 1'b1;
                if_dat_o <= wb_dat_i;
              end
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          cyc_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter.
// Two instances run side by side: index 0 with LSU_PRIO=1, index 1 with
// LSU_PRIO=0. Each has its own simple Wishbone slave. A transaction-level
// model predicts every output of both instances each cycle; directed tests add
// literal expectations for latency, data and arbitration order.

module tb_mem_bus_arbiter;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic [31:0] if_dat   [2];
  logic        if_ack   [2];
  logic        if_err   [2];
  logic        lsu_re   [2];
  logic        lsu_we   [2];
  logic [3:0]  lsu_sel  [2];
  logic [31:0] lsu_addr [2];
  logic [31:0] lsu_wdat [2];
  logic [31:0] lsu_rdat [2];
  logic        lsu_ack  [2];
  logic        lsu_err  [2];
  logic        wb_cyc   [2];
  logic        wb_stb   [2];
  logic        wb_we    [2];
  logic [3:0]  wb_sel   [2];
  logic [31:0] wb_adr   [2];
  logic [31:0] wb_wdat  [2];
  logic [31:0] wb_rdat  [2];
  logic        wb_ack   [2];
  logic        wb_err   [2];

  mem_bus_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_dat_o(if_dat[0]),
    .if_ack_o(if_ack[0]), .if_err_o(if_err[0]),
    .lsu_re_i(lsu_re[0]), .lsu_we_i(lsu_we[0]), .lsu_sel_i(lsu_sel[0]),
    .lsu_addr_i(lsu_addr[0]), .lsu_dat_i(lsu_wdat[0]), .lsu_dat_o(lsu_rdat[0]),
    .lsu_ack_o(lsu_ack[0]), .lsu_err_o(lsu_err[0]),
    .wb_cyc_o(wb_cyc[0]), .wb_stb_o(wb_stb[0]), .wb_we_o(wb_we[0]),
    .wb_sel_o(wb_sel[0]), .wb_adr_o(wb_adr[0]), .wb_dat_o(wb_wdat[0]),
    .wb_dat_i(wb_rdat[0]), .wb_ack_i(wb_ack[0]), .wb_err_i(wb_err[0])
  );

  mem_bus_arbiter #(.LSU_PRIO(1'b0), .TIMEOUT_CYCLES(TMO)) u_alt (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_dat_o(if_dat[1]),
    .if_ack_o(if_ack[1]), .if_err_o(if_err[1]),
    .lsu_re_i(lsu_re[1]), .lsu_we_i(lsu_we[1]), .lsu_sel_i(lsu_sel[1]),
    .lsu_addr_i(lsu_addr[1]), .lsu_dat_i(lsu_wdat[1]), .lsu_dat_o(lsu_rdat[1]),
    .lsu_ack_o(lsu_ack[1]), .lsu_err_o(lsu_err[1]),
    .wb_cyc_o(wb_cyc[1]), .wb_stb_o(wb_stb[1]), .wb_we_o(wb_we[1]),
    .wb_sel_o(wb_sel[1]), .wb_adr_o(wb_adr[1]), .wb_dat_o(wb_wdat[1]),
    .wb_dat_i(wb_rdat[1]), .wb_ack_i(wb_ack[1]), .wb_err_i(wb_err[1])
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave: responds after sl_wait cycles of cyc ----------------
  // sl_mode: 0 ack, 1 err, 2 ack+err together, 3 silent
  int          sl_wait [2];
  int          sl_mode [2];
  logic [31:0] sl_data [2];
  bit          sl_late [2];
  int          sl_cnt  [2];

  task automatic slave_step(input int i);
    bit hit;
    hit = 1'b0;
    if (wb_cyc[i] !== 1'b1) begin
      sl_cnt[i] = 0;
    end else begin
      hit = (sl_cnt[i] == sl_wait[i]);
      sl_cnt[i]++;
    end
    wb_ack[i]  = (hit && (sl_mode[i] == 0 || sl_mode[i] == 2)) || sl_late[i];
    wb_err[i]  = hit && (sl_mode[i] == 1 || sl_mode[i] == 2);
    wb_rdat[i] = sl_data[i];
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) slave_step(i);
  end

  // ---------------- transaction-level model ----------------
  bit          m_busy [2];
  bit          m_lsu  [2];
  bit          m_we   [2];
  bit          m_last_lsu [2];
  logic [3:0]  m_sel  [2];
  logic [31:0] m_adr  [2];
  logic [31:0] m_wdat [2];
  int          m_age  [2];

  bit          e_if_ack [2];
  bit          e_if_err [2];
  bit          e_lsu_ack[2];
  bit          e_lsu_err[2];
  logic [31:0] e_if_dat [2];
  logic [31:0] e_lsu_dat[2];

  task automatic model_step(input int i);
    bit if_hit, lsu_hit, if_el, lsu_el, pick_lsu, done, fail;
    if_hit  = e_if_ack[i] || e_if_err[i];
    lsu_hit = e_lsu_ack[i] || e_lsu_err[i];
    e_if_ack[i]  = 1'b0;  e_if_err[i]  = 1'b0;  e_if_dat[i]  = 32'h0;
    e_lsu_ack[i] = 1'b0;  e_lsu_err[i] = 1'b0;  e_lsu_dat[i] = 32'h0;
    if (rst_i !== 1'b1) begin
      m_busy[i]     = 1'b0;
      m_last_lsu[i] = 1'b1;
      m_age[i]      = 0;
    end else if (m_busy[i]) begin
      done = 1'b0;
      fail = 1'b0;
      if (wb_err[i] === 1'b1) begin
        done = 1'b1; fail = 1'b1;
      end else if (wb_ack[i] === 1'b1) begin
        done = 1'b1;
      end else if (TMO_EN && m_age[i] >= TMO) begin
        done = 1'b1; fail = 1'b1;
      end else begin
        m_age[i]++;
      end
      if (done) begin
        m_busy[i] = 1'b0;
        if (m_lsu[i]) begin
          e_lsu_err[i] = fail;
          e_lsu_ack[i] = !fail;
          e_lsu_dat[i] = (fail || m_we[i]) ? 32'h0 : wb_rdat[i];
        end else begin
          e_if_err[i] = fail;
          e_if_ack[i] = !fail;
          e_if_dat[i] = fail ? 32'h0 : wb_rdat[i];
        end
      end
    end else begin
      if_el  = (if_req[i] === 1'b1) && !if_hit;
      lsu_el = (lsu_re[i] === 1'b1 || lsu_we[i] === 1'b1) && !lsu_hit;
      if (if_el && lsu_el) pick_lsu = (i == 0) ? 1'b1 : !m_last_lsu[i];
      else                 pick_lsu = lsu_el;
      if (if_el || lsu_el) begin
        m_busy[i]     = 1'b1;
        m_age[i]      = 0;
        m_lsu[i]      = pick_lsu;
        m_last_lsu[i] = pick_lsu;
        if (pick_lsu) begin
          m_we[i]   = lsu_we[i];
          m_sel[i]  = lsu_sel[i];
          m_adr[i]  = lsu_addr[i];
          m_wdat[i] = lsu_wdat[i];
        end else begin
          m_we[i]   = 1'b0;
          m_sel[i]  = 4'hF;
          m_adr[i]  = if_addr[i];
          m_wdat[i] = 32'h0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // compare every output of both instances on every falling edge
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("i%0d wb_cyc", i),  32'(wb_cyc[i]),  32'(m_busy[i]));
        check($sformatf("i%0d wb_stb", i),  32'(wb_stb[i]),  32'(m_busy[i]));
        check($sformatf("i%0d wb_we", i),   32'(wb_we[i]),   32'(m_busy[i] && m_we[i]));
        check($sformatf("i%0d wb_sel", i),  32'(wb_sel[i]),  m_busy[i] ? 32'(m_sel[i]) : 32'h0);
        check($sformatf("i%0d wb_adr", i),  wb_adr[i],       m_busy[i] ? m_adr[i] : 32'h0);
        check($sformatf("i%0d wb_dat", i),  wb_wdat[i],      m_busy[i] ? m_wdat[i] : 32'h0);
        check($sformatf("i%0d if_ack", i),  32'(if_ack[i]),  32'(e_if_ack[i]));
        check($sformatf("i%0d if_err", i),  32'(if_err[i]),  32'(e_if_err[i]));
        check($sformatf("i%0d if_dat", i),  if_dat[i],       e_if_dat[i]);
        check($sformatf("i%0d lsu_ack", i), 32'(lsu_ack[i]), 32'(e_lsu_ack[i]));
        check($sformatf("i%0d lsu_err", i), 32'(lsu_err[i]), 32'(e_lsu_err[i]));
        check($sformatf("i%0d lsu_dat", i), lsu_rdat[i],     e_lsu_dat[i]);
      end
    end
  end

  // ---------------- requester helpers ----------------
  task automatic start_if(input int i, input logic [31:0] a);
    @(negedge clk);
    if_req[i]  = 1'b1;
    if_addr[i] = a;
  endtask

  task automatic start_lsu(input int i, input bit re, input bit we, input logic [3:0] sel,
                           input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    lsu_re[i]   = re;
    lsu_we[i]   = we;
    lsu_sel[i]  = sel;
    lsu_addr[i] = a;
    lsu_wdat[i] = d;
  endtask

  // waits (bounded) for the port's ack/err, drops the request on that cycle
  task automatic wait_done(input int i, input bit lsu, output bit ack, output bit err,
                           output logic [31:0] dat, output int n);
    bit seen;
    seen = 1'b0; ack = 1'b0; err = 1'b0; dat = 32'h0; n = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (lsu ? (lsu_ack[i] === 1'b1 || lsu_err[i] === 1'b1)
              : (if_ack[i] === 1'b1 || if_err[i] === 1'b1)) begin
        seen = 1'b1;
        n    = k;
        ack  = lsu ? lsu_ack[i] : if_ack[i];
        err  = lsu ? lsu_err[i] : if_err[i];
        dat  = lsu ? lsu_rdat[i] : if_dat[i];
      end
    end
    if (lsu) begin lsu_re[i] = 1'b0; lsu_we[i] = 1'b0; end
    else     if_req[i] = 1'b0;
    check($sformatf("i%0d completion within bound", i), 32'(seen), 32'd1);
  endtask

  // both ports request in the same cycle; returns which port completed first
  task automatic run_tie(input int i, output int first);
    bit if_done, lsu_done;
    if_done = 1'b0; lsu_done = 1'b0; first = -1;
    @(negedge clk);
    if_req[i]  = 1'b1;  if_addr[i]  = 32'h40;
    lsu_re[i]  = 1'b1;  lsu_we[i]   = 1'b0;
    lsu_sel[i] = 4'hF;  lsu_addr[i] = 32'h80;  lsu_wdat[i] = 32'h0;
    for (int k = 0; k < 40 && !(if_done && lsu_done); k++) begin
      @(negedge clk);
      if (if_ack[i] === 1'b1) begin
        if (first < 0) first = 0;
        if_req[i] = 1'b0; if_done = 1'b1;
      end
      if (lsu_ack[i] === 1'b1) begin
        if (first < 0) first = 1;
        lsu_re[i] = 1'b0; lsu_done = 1'b1;
      end
    end
    if_req[i] = 1'b0;
    lsu_re[i] = 1'b0;
    check($sformatf("i%0d tie both served", i), 32'(if_done && lsu_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    bit          ack, err;
    logic [31:0] dat;
    int          n, first, n_ack, kk;

    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0;  if_addr[i] = 32'h0;
      lsu_re[i] = 1'b0;  lsu_we[i] = 1'b0;  lsu_sel[i] = 4'h0;
      lsu_addr[i] = 32'h0;  lsu_wdat[i] = 32'h0;
      wb_ack[i] = 1'b0;  wb_err[i] = 1'b0;  wb_rdat[i] = 32'h0;
      sl_wait[i] = 0;  sl_mode[i] = 0;  sl_data[i] = 32'h0;  sl_late[i] = 1'b0;
      sl_cnt[i] = 0;
    end

    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset cyc",     32'(wb_cyc[0]),  32'd0);
    check("reset if_ack",  32'(if_ack[0]),  32'd0);
    check("reset lsu_err", 32'(lsu_err[1]), 32'd0);
    check("reset adr",     wb_adr[0],       32'h0);
    rst_i = 1'b1;

    // fetch read, zero-wait slave: cyc at N+1, ack at N+2, single pulse
    sl_mode[0] = 0; sl_wait[0] = 0; sl_data[0] = 32'hDEADBEEF;
    start_if(0, 32'h100);
    @(negedge clk);
    check("t1 cyc at N+1", 32'(wb_cyc[0]), 32'd1);
    check("t1 adr",        wb_adr[0],      32'h100);
    check("t1 sel",        32'(wb_sel[0]), 32'hF);
    check("t1 we",         32'(wb_we[0]),  32'd0);
    @(negedge clk);
    check("t1 ack at N+2", 32'(if_ack[0]), 32'd1);
    check("t1 data",       if_dat[0],      32'hDEADBEEF);
    if_req[0] = 1'b0;
    @(negedge clk);
    check("t1 ack single pulse", 32'(if_ack[0]), 32'd0);
    check("t1 data cleared",     if_dat[0],      32'h0);

    // held fetch request: one transfer per three cycles
    sl_data[0] = 32'h11110000;
    start_if(0, 32'h104);
    n_ack = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (if_ack[0] === 1'b1) n_ack++;
    end
    if_req[0] = 1'b0;
    check("throughput acks in 9 cycles", 32'(n_ack), 32'd3);

    // LSU byte write with re and we both set (write wins), two wait states
    sl_wait[0] = 2;
    start_lsu(0, 1'b1, 1'b1, 4'b0100, 32'h2000, 32'h5A5A5A5A);
    @(negedge clk);
    check("t2 we",  32'(wb_we[0]),  32'd1);
    check("t2 sel", 32'(wb_sel[0]), 32'h4);
    check("t2 adr", wb_adr[0],      32'h2000);
    check("t2 dat", wb_wdat[0],     32'h5A5A5A5A);
    wait_done(0, 1'b1, ack, err, dat, n);
    check("t2 ack",     32'(ack), 32'd1);
    check("t2 err",     32'(err), 32'd0);
    check("t2 dat_o",   dat,      32'h0);
    check("t2 latency", 32'(n),   32'd3);

    // LSU read, plain ack
    sl_wait[0] = 0; sl_mode[0] = 0; sl_data[0] = 32'h12345678;
    start_lsu(0, 1'b1, 1'b0, 4'hF, 32'h3000, 32'hFFFFFFFF);
    wait_done(0, 1'b1, ack, err, dat, n);
    check("rd ack",     32'(ack), 32'd1);
    check("rd data",    dat,      32'h12345678);
    check("rd latency", 32'(n),   32'd2);

    // ack and err together: error wins, data forced to 0
    sl_mode[0] = 2; sl_data[0] = 32'hCAFEF00D;
    start_lsu(0, 1'b1, 1'b0, 4'hF, 32'h3004, 32'h0);
    wait_done(0, 1'b1, ack, err, dat, n);
    check("t4 lsu_ack", 32'(ack), 32'd0);
    check("t4 lsu_err", 32'(err), 32'd1);
    check("t4 lsu_dat", dat,      32'h0);

    // fetch error
    sl_mode[0] = 1;
    start_if(0, 32'h200);
    wait_done(0, 1'b0, ack, err, dat, n);
    check("if err",     32'(err), 32'd1);
    check("if err ack", 32'(ack), 32'd0);
    check("if err dat", dat,      32'h0);

    // fetch request dropped mid-bus: cycle still completes
    sl_mode[0] = 0; sl_wait[0] = 1; sl_data[0] = 32'h600DF00D;
    start_if(0, 32'h300);
    @(negedge clk);
    check("drop cyc", 32'(wb_cyc[0]), 32'd1);
    if_req[0] = 1'b0;
    @(negedge clk);
    check("drop no early ack", 32'(if_ack[0]), 32'd0);
    @(negedge clk);
    check("drop ack", 32'(if_ack[0]), 32'd1);
    check("drop dat", if_dat[0],      32'h600DF00D);

    // arbitration ties on both instances
    for (int i = 0; i < 2; i++) begin
      sl_mode[i] = 0; sl_wait[i] = 0; sl_data[i] = 32'h0000A000 + 32'(i);
    end
    run_tie(0, first);
    check("prio1 round1 first=LSU", 32'(first), 32'd1);
    start_if(0, 32'h44);
    wait_done(0, 1'b0, ack, err, dat, n);
    run_tie(0, first);
    check("prio1 round2 first=LSU", 32'(first), 32'd1);

    run_tie(1, first);
    check("prio0 round1 first=IF", 32'(first), 32'd0);
    start_if(1, 32'h44);
    wait_done(1, 1'b0, ack, err, dat, n);
    check("prio0 lone fetch ack", 32'(ack), 32'd1);
    run_tie(1, first);
    check("prio0 round2 first=LSU", 32'(first), 32'd1);

    // reset while an LSU cycle is waiting on a silent slave
    sl_mode[0] = 3;
    start_lsu(0, 1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
    @(negedge clk);
    check("t6 cyc", 32'(wb_cyc[0]), 32'd1);
    @(negedge clk);
    check("t6 cyc wait", 32'(wb_cyc[0]), 32'd1);
    rst_i = 1'b0;
    lsu_re[0] = 1'b0;
    @(negedge clk);
    check("t6 cyc dropped", 32'(wb_cyc[0]),  32'd0);
    check("t6 no ack",      32'(lsu_ack[0]), 32'd0);
    check("t6 no err",      32'(lsu_err[0]), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    check("t6 still quiet", 32'(lsu_ack[0] | lsu_err[0]), 32'd0);
    sl_mode[0] = 0; sl_data[0] = 32'hA5A50001;
    start_lsu(0, 1'b1, 1'b0, 4'hF, 32'h4004, 32'h0);
    wait_done(0, 1'b1, ack, err, dat, n);
    check("t6 fresh ack",     32'(ack), 32'd1);
    check("t6 fresh data",    dat,      32'hA5A50001);
    check("t6 fresh latency", 32'(n),   32'd2);

`ifdef MEM_TIMEOUT_EN
    // watchdog: silent slave, err pulse 5 cycles after cyc rises, late ack ignored
    sl_mode[0] = 3;
    start_lsu(0, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0);
    @(negedge clk);
    check("t5 cyc", 32'(wb_cyc[0]), 32'd1);
    kk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lsu_err[0] === 1'b1) begin
        kk = k;
        break;
      end
    end
    check("t5 err delay", 32'(kk),         32'd5);
    check("t5 cyc low",   32'(wb_cyc[0]),  32'd0);
    check("t5 no ack",    32'(lsu_ack[0]), 32'd0);
    lsu_re[0]  = 1'b0;
    sl_late[0] = 1'b1;
    @(negedge clk);
    sl_late[0] = 1'b0;
    check("t5 late ack ignored", 32'(lsu_ack[0]), 32'd0);
    check("t5 idle after late",  32'(wb_cyc[0]),  32'd0);
    sl_mode[0] = 0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
